// File: rtl/vec_mac_unit.sv
// vec_mac_unit: streaming signed fixed-point dot-product engine.
// Each beat multiplies EP lane pairs (stage P) and sums them in a registered
// adder tree (stage S). Stage A accumulates across beats until in_last, then
// converts the total to Q(WIO.WFO) with saturation and presents it on a
// valid/ready output. The whole pipeline stalls while a result waits.
module vec_mac_unit #(
  parameter int EP    = 3,
  parameter int WI1   = 4,
  parameter int WF1   = 12,
  parameter int WI2   = 4,
  parameter int WF2   = 12,
  parameter int WIO   = 10,
  parameter int WFO   = 22,
  parameter int GUARD = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [EP*(WI1+WF1)-1:0]      in1,
  input  logic [EP*(WI2+WF2)-1:0]      in2,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [WIO+WFO-1:0]           out_data,
  output logic                         out_ovf,
  output logic                         out_valid,
  input  logic                         out_ready
);

  // Lane widths and derived internal formats
  localparam int W1  = WI1 + WF1;              // in1 lane width
  localparam int W2  = WI2 + WF2;              // in2 lane width
  localparam int PW  = W1 + W2;                // full-precision product width
  localparam int LG  = (EP > 1) ? $clog2(EP) : 0; // tree growth bits
  localparam int SW  = PW + LG;                // tree sum width
  localparam int FIN = WF1 + WF2;              // internal fraction bits
  localparam int AW  = WI1 + WI2 + LG + GUARD + FIN; // accumulator width
  localparam int OW  = WIO + WFO;              // output width

  // Alignment of the internal fraction to the output fraction
  localparam int RSH = (FIN > WFO) ? (FIN - WFO) : 0;
  localparam int LSH = (WFO > FIN) ? (WFO - FIN) : 0;

  // Conversion workspace: wide enough for the aligned accumulator and the
  // output limits, plus one bit so the limits compare as signed numbers.
  localparam int CW  = (((AW + LSH) > OW) ? (AW + LSH) : OW) + 1;

  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [CW-1:0] OUT_MAX = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [CW-1:0] OUT_MIN = ~OUT_MAX;

  // Global advance: everything moves unless a result is stuck at the output
  logic adv_s;

  // Stage P
  logic signed [PW-1:0] prod_s [EP];
  logic signed [PW-1:0] prod_r [EP];
  logic                 p_valid_r;
  logic                 p_last_r;

  // Stage S
  logic signed [SW-1:0] tree_s;
  logic signed [SW-1:0] s_sum_r;
  logic                 s_valid_r;
  logic                 s_last_r;

  // Stage A
  logic signed [AW-1:0] acc_r;
  logic                 sticky_r;
  logic signed [AW:0]   acc_sum_s;
  logic                 acc_ovf_s;
  logic signed [AW-1:0] acc_sat_s;

  // Output conversion
  logic signed [CW-1:0] conv_ext_s;
  logic signed [CW-1:0] conv_shift_s;
  logic                 conv_sat_s;
  logic [OW-1:0]        conv_data_s;
  logic                 res_ovf_s;

  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;

  // Lane products at full precision; the product always fits in PW bits
  always_comb begin
    for (int i = 0; i < EP; i++) begin
      prod_s[i] = PW'($signed(in1[i*W1 +: W1])) * PW'($signed(in2[i*W2 +: W2]));
    end
  end

  // Stage P registers: products plus beat qualifiers; in_last only counts with in_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < EP; i++) begin
        prod_r[i] <= '0;
      end
      p_valid_r <= 1'b0;
      p_last_r  <= 1'b0;
    end else if (adv_s) begin
      for (int i = 0; i < EP; i++) begin
        prod_r[i] <= prod_s[i];
      end
      p_valid_r <= in_valid;
      p_last_r  <= in_valid && in_last;
    end
  end

  // Adder tree over the registered products, sign-extended so it cannot wrap
  always_comb begin
    tree_s = '0;
    for (int i = 0; i < EP; i++) begin
      tree_s = tree_s + SW'(prod_r[i]);
    end
  end

  // Stage S registers: reduced beat sum and its qualifiers
  always_ff @(posedge clk) begin
    if (reset) begin
      s_sum_r   <= '0;
      s_valid_r <= 1'b0;
      s_last_r  <= 1'b0;
    end else if (adv_s) begin
      s_sum_r   <= tree_s;
      s_valid_r <= p_valid_r;
      s_last_r  <= p_last_r;
    end
  end

  // Accumulator add with one extra bit, clamped back into the accumulator range
  always_comb begin
    acc_sum_s = (AW+1)'(acc_r) + (AW+1)'(s_sum_r);
    acc_ovf_s = 1'b0;
    acc_sat_s = acc_sum_s[AW-1:0];
    if (acc_sum_s[AW] != acc_sum_s[AW-1]) begin
      acc_ovf_s = 1'b1;
      if (acc_sum_s[AW]) begin
        acc_sat_s = ACC_MIN;
      end else begin
        acc_sat_s = ACC_MAX;
      end
    end else begin
      acc_ovf_s = 1'b0;
    end
  end

  // Convert the running total to the output format: floor the fraction, saturate the integer
  always_comb begin
    conv_ext_s   = CW'(acc_sat_s);
    conv_shift_s = (conv_ext_s >>> RSH) <<< LSH;
    conv_sat_s   = 1'b0;
    conv_data_s  = conv_shift_s[OW-1:0];
    if (conv_shift_s > OUT_MAX) begin
      conv_sat_s  = 1'b1;
      conv_data_s = OUT_MAX[OW-1:0];
    end else if (conv_shift_s < OUT_MIN) begin
      conv_sat_s  = 1'b1;
      conv_data_s = OUT_MIN[OW-1:0];
    end else begin
      conv_sat_s  = 1'b0;
    end
    res_ovf_s = conv_sat_s || acc_ovf_s || sticky_r;
  end

  // Stage A: accumulate non-last beats, clear on the last beat; bubbles leave acc alone
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r    <= '0;
      sticky_r <= 1'b0;
    end else if (adv_s && s_valid_r) begin
      if (s_last_r) begin
        acc_r    <= '0;
        sticky_r <= 1'b0;
      end else begin
        acc_r    <= acc_sat_s;
        sticky_r <= sticky_r || acc_ovf_s;
      end
    end
  end

  // Output register: load on a last beat, drop valid when drained with nothing new
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv_s) begin
      out_valid <= s_valid_r && s_last_r;
      if (s_valid_r && s_last_r) begin
        out_data <= conv_data_s;
        out_ovf  <= res_ovf_s;
      end
    end
  end

endmodule

// File: tb/tb_vec_mac_unit.sv
// Directed bench for vec_mac_unit with default parameters (EP=3, Q4.12 inputs,
// Q10.22 output). Expected values are hand-computed constants.
module tb_vec_mac_unit;

  localparam int EP = 3;
  localparam int LW = 16;
  localparam int IW = EP * LW;
  localparam int OW = 32;

  localparam logic [IW-1:0] ALL1 = {EP{16'h1000}};  // 1.0 in every lane
  localparam logic [IW-1:0] ALLN = {EP{16'h8000}};  // -8.0 in every lane

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] in1;
  logic [IW-1:0] in2;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_ovf;
  logic          out_valid;
  logic          out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [OW:0] res_q [$];   // {ovf, data} of every result handed downstream

  vec_mac_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in1       (in1),
    .in2       (in2),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Record each result that will be accepted at the coming rising edge
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) res_q.push_back({out_ovf, out_data});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] lane0(input logic [15:0] v);
    return {{(IW-16){1'b0}}, v};
  endfunction

  // Present one beat and hold it until the handshake completes
  task automatic send(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic last);
    bit done = 1'b0;
    in1 = a; in2 = b; in_valid = 1'b1; in_last = last;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check_eq("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait for n results, then a few more cycles to catch any extra one
  task automatic drain_check(input string tag, input int n);
    for (int c = 0; c < 100 && res_q.size() < n; c++) begin
      @(posedge clk);
      #1;
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_count"}, 64'(res_q.size()), 64'(n));
  endtask

  task automatic pop_check(input string tag, input logic [OW-1:0] d, input logic o);
    logic [OW:0] r;
    if (res_q.size() == 0) begin
      check_eq({tag, "_empty"}, 64'd0, 64'd1);
    end else begin
      r = res_q.pop_front();
      check_eq({tag, "_data"}, 64'(r[OW-1:0]), 64'(d));
      check_eq({tag, "_ovf"}, 64'(r[OW]), 64'(o));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in1 = '0; in2 = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_data", 64'(out_data), 64'd0);
    check_eq("rst_ovf", 64'(out_ovf), 64'd0);
    check_eq("rst_ready", 64'(in_ready), 64'd1);

    // Single beat: 3 lanes of 1.0*1.0 = 3.0, valid after the third edge
    send(ALL1, ALL1, 1'b1);
    check_eq("lat_e0", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("lat_e1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("lat_e2", 64'(out_valid), 64'd1);
    check_eq("lat_data", 64'(out_data), 64'h00C00000);
    check_eq("lat_ovf", 64'(out_ovf), 64'd0);
    drain_check("one", 1);
    pop_check("one", 32'h00C00000, 1'b0);

    // Four beats accumulate to 12.0, one result only
    for (int i = 0; i < 4; i++) send(ALL1, ALL1, (i == 3));
    drain_check("four", 1);
    pop_check("four", 32'h03000000, 1'b0);

    // 3 x 192 = 576 exceeds the output range; next product back-to-back is clean
    for (int i = 0; i < 3; i++) send(ALLN, ALLN, (i == 2));
    send(ALL1, ALL1, 1'b1);
    drain_check("sat", 2);
    pop_check("sat", 32'h7FFFFFFF, 1'b1);
    pop_check("after_sat", 32'h00C00000, 1'b0);

    // Truncation toward -inf of the two dropped fraction bits
    send(lane0(16'h0001), lane0(16'h0001), 1'b1);
    send(lane0(16'hFFFF), lane0(16'h0001), 1'b1);
    drain_check("trunc", 2);
    pop_check("trunc_pos", 32'h00000000, 1'b0);
    pop_check("trunc_neg", 32'hFFFFFFFF, 1'b0);

    // Backpressure: first result held while 5 more products wait upstream
    out_ready = 1'b0;
    send(lane0(16'h1000), ALL1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("stall_valid", 64'(out_valid), 64'd1);
    check_eq("stall_ready0", 64'(in_ready), 64'd0);
    check_eq("stall_data0", 64'(out_data), 64'h00400000);
    fork
      begin
        for (int k = 2; k <= 6; k++) send(lane0(16'(k * 4096)), ALL1, 1'b1);
      end
      begin
        repeat (6) begin
          @(posedge clk); #1;
          check_eq("stall_hold", 64'(out_data), 64'h00400000);
          check_eq("stall_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
      end
    join
    drain_check("stall", 6);
    for (int k = 1; k <= 6; k++) pop_check($sformatf("stall_r%0d", k), 32'(k) << 22, 1'b0);

    // Reset with a partial sum in the accumulator: nothing leaks out
    send(ALL1, ALL1, 1'b0);
    send(ALL1, ALL1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("abort_valid", 64'(out_valid), 64'd0);
    send(ALL1, ALL1, 1'b1);
    drain_check("abort", 1);
    pop_check("abort", 32'h00C00000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
